// File: rtl/cascade_slave_responder_pkg.sv
// Shared definitions for the 8259 cascade slave responder: FSM encoding,
// the spurious-acknowledge level and the level-to-ISR-bit decode.
package cascade_slave_responder_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'b00,
        STATE_ACK1  = 2'b01,
        STATE_ACK2  = 2'b10,
        STATE_WAIT2 = 2'b11
    } control_state_t;

    // An acknowledge with nothing pending is answered as IR7.
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
        level_to_onehot = 8'h01 << level;
    endfunction

endpackage

// File: rtl/cascade_slave_responder_inta_edge_detect.sv
// Falling/rising edge detector for the synchronous INTA strobe.
module cascade_slave_responder_inta_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic interrupt_acknowledge_n,
    output logic fall,
    output logic rise
);

    logic inta_prev_r;

    // Previous INTA level; reset high so a low pin after reset reads as a fall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inta_prev_r <= 1'b1;
        end else begin
            inta_prev_r <= interrupt_acknowledge_n;
        end
    end

    assign fall = inta_prev_r & ~interrupt_acknowledge_n;
    assign rise = ~inta_prev_r & interrupt_acknowledge_n;

endmodule

// File: rtl/cascade_slave_responder.sv
// Slave end of the 8259 cascade bus: follows the two-pulse INTA sequence,
// matches the CAS ID against ICW3 and supplies the ISR set and vector.
module cascade_slave_responder
    import cascade_slave_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_initial_command_word_1_reset,
    input  logic       slave_mode,
    input  logic [2:0] slave_id,
    input  logic       interrupt_acknowledge_n,
    input  logic [2:0] cascade_in,
    input  logic       interrupt_pending,
    input  logic [2:0] highest_level,
    input  logic [4:0] vector_base,
    output logic       selected,
    output logic [7:0] in_service_set,
    output logic [7:0] data_out,
    output logic       data_out_enable,
    output logic       acknowledge_done,
    output logic [1:0] control_state
);

    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO  = COUNT_WIDTH'(0);

    control_state_t         state_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [2:0]             level_r;
    logic                   selected_r;
    logic [7:0]             in_service_set_r;
    logic [7:0]             data_out_r;
    logic                   data_out_enable_r;
    logic                   acknowledge_done_r;

    logic                   fall_s;
    logic                   rise_s;
    logic                   id_match_s;
    logic [2:0]             ack_level_s;
    logic                   drive_s;
    logic [COUNT_WIDTH-1:0] count_next_s;

    cascade_slave_responder_inta_edge_detect u_inta_edge_detect (
        .clock                   (clock),
        .reset                   (reset),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .fall                    (fall_s),
        .rise                    (rise_s)
    );

    assign id_match_s   = slave_mode & (cascade_in == slave_id);
    assign ack_level_s  = interrupt_pending ? highest_level : SPURIOUS_LEVEL;
    assign drive_s      = selected_r & ~interrupt_acknowledge_n;
    assign count_next_s = count_r + COUNT_ONE;

    // INTA sequencer with registered cascade-side and data-bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r            <= STATE_IDLE;
            count_r            <= COUNT_ZERO;
            level_r            <= 3'd0;
            selected_r         <= 1'b0;
            in_service_set_r   <= 8'h00;
            data_out_r         <= 8'h00;
            data_out_enable_r  <= 1'b0;
            acknowledge_done_r <= 1'b0;
        end else if (write_initial_command_word_1_reset) begin
            state_r            <= STATE_IDLE;
            count_r            <= COUNT_ZERO;
            level_r            <= 3'd0;
            selected_r         <= 1'b0;
            in_service_set_r   <= 8'h00;
            data_out_r         <= 8'h00;
            data_out_enable_r  <= 1'b0;
            acknowledge_done_r <= 1'b0;
        end else begin
            in_service_set_r   <= 8'h00;
            acknowledge_done_r <= 1'b0;
            case (state_r)
                STATE_IDLE: begin
                    if (fall_s) begin
                        state_r    <= STATE_ACK1;
                        selected_r <= 1'b0;
                    end
                end
                STATE_ACK1: begin
                    if (rise_s) begin
                        selected_r       <= id_match_s;
                        level_r          <= ack_level_s;
                        in_service_set_r <= (id_match_s & interrupt_pending) ?
                                            level_to_onehot(ack_level_s) : 8'h00;
                        count_r          <= COUNT_ZERO;
                        state_r          <= STATE_WAIT2;
                    end
                end
                STATE_WAIT2: begin
                    count_r <= count_next_s;
                    // A second INTA landing on the timeout cycle still wins.
                    if (fall_s) begin
                        state_r           <= STATE_ACK2;
                        data_out_enable_r <= drive_s;
                        data_out_r        <= drive_s ? {vector_base, level_r} : 8'h00;
                    end else if (count_next_s == COUNT_LIMIT) begin
                        state_r    <= STATE_IDLE;
                        selected_r <= 1'b0;
                    end
                end
                STATE_ACK2: begin
                    if (rise_s) begin
                        data_out_enable_r  <= 1'b0;
                        data_out_r         <= 8'h00;
                        acknowledge_done_r <= 1'b1;
                        state_r            <= STATE_IDLE;
                    end else begin
                        data_out_enable_r <= drive_s;
                        data_out_r        <= drive_s ? {vector_base, level_r} : 8'h00;
                    end
                end
                default: begin
                    state_r           <= STATE_IDLE;
                    selected_r        <= 1'b0;
                    data_out_enable_r <= 1'b0;
                    data_out_r        <= 8'h00;
                end
            endcase
        end
    end

    assign selected         = selected_r;
    assign in_service_set   = in_service_set_r;
    assign data_out         = data_out_r;
    assign data_out_enable  = data_out_enable_r;
    assign acknowledge_done = acknowledge_done_r;
    assign control_state    = state_r;

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Self-checking bench for cascade_slave_responder: directed table of INTA
// transactions, randomized transactions against a transaction-level model.
module tb_cascade_slave_responder;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       icw1;
    logic       slave_mode;
    logic [2:0] slave_id;
    logic       inta_n;
    logic [2:0] cascade_in;
    logic       interrupt_pending;
    logic [2:0] highest_level;
    logic [4:0] vector_base;
    logic       selected;
    logic [7:0] in_service_set;
    logic [7:0] data_out;
    logic       data_out_enable;
    logic       acknowledge_done;
    logic [1:0] control_state;

    int checks = 0;
    int errors = 0;

    cascade_slave_responder #(.TIMEOUT_CYCLES(T)) dut (
        .clock                              (clock),
        .reset                              (reset),
        .write_initial_command_word_1_reset (icw1),
        .slave_mode                         (slave_mode),
        .slave_id                           (slave_id),
        .interrupt_acknowledge_n            (inta_n),
        .cascade_in                         (cascade_in),
        .interrupt_pending                  (interrupt_pending),
        .highest_level                      (highest_level),
        .vector_base                        (vector_base),
        .selected                           (selected),
        .in_service_set                     (in_service_set),
        .data_out                           (data_out),
        .data_out_enable                    (data_out_enable),
        .acknowledge_done                   (acknowledge_done),
        .control_state                      (control_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       mode;
        logic [2:0] id;
        logic [2:0] cas;
        logic       pending;
        logic [2:0] level;
        logic [4:0] vb;
        int         gap;
        logic [7:0] exp_isr;
        logic       exp_sel;
        logic [7:0] exp_data;
        logic       exp_timeout;
    } vec_t;

    vec_t table_v[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction-level reference: what the slave should answer for one INTA pair.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [2:0] lvl;
        r.exp_sel     = v.mode && (v.cas == v.id);
        lvl           = v.pending ? v.level : 3'd7;
        r.exp_isr     = (r.exp_sel && v.pending) ? (8'd1 << lvl) : 8'd0;
        r.exp_data    = r.exp_sel ? {v.vb, lvl} : 8'd0;
        r.exp_timeout = (v.gap >= T);
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input int low1, input int low2, input bit scramble);
        slave_mode        = v.mode;
        slave_id          = v.id;
        cascade_in        = v.cas;
        interrupt_pending = v.pending;
        highest_level     = v.level;
        vector_base       = v.vb;
        inta_n            = 1'b0;
        for (int i = 0; i < low1; i++) begin
            tick();
            check("ack1_state", {6'd0, control_state}, 8'h01);
            check("ack1_selected_clear", {7'd0, selected}, 8'h00);
            check("ack1_no_isr", in_service_set, 8'h00);
        end
        inta_n = 1'b1;
        tick();
        check("rise_state", {6'd0, control_state}, 8'h03);
        check("rise_isr", in_service_set, v.exp_isr);
        check("rise_selected", {7'd0, selected}, {7'd0, v.exp_sel});
        if (scramble) begin
            slave_mode        = $urandom_range(0, 1);
            slave_id          = $urandom_range(0, 7);
            cascade_in        = $urandom_range(0, 7);
            interrupt_pending = $urandom_range(0, 1);
            highest_level     = $urandom_range(0, 7);
        end
        for (int i = 1; i <= v.gap; i++) begin
            tick();
            check("wait2_state", {6'd0, control_state}, (i >= T) ? 8'h00 : 8'h03);
            if (i == 1) check("isr_single_pulse", in_service_set, 8'h00);
        end
        if (v.exp_timeout) begin
            check("timeout_selected", {7'd0, selected}, 8'h00);
            check("timeout_no_done", {7'd0, acknowledge_done}, 8'h00);
            check("timeout_no_drive", {7'd0, data_out_enable}, 8'h00);
            return;
        end
        inta_n = 1'b0;
        tick();
        check("ack2_state", {6'd0, control_state}, 8'h02);
        for (int j = 1; j < low2; j++) tick();
        check("ack2_state_held", {6'd0, control_state}, 8'h02);
        check("ack2_enable", {7'd0, data_out_enable}, {7'd0, v.exp_sel});
        check("ack2_data", data_out, v.exp_data);
        inta_n = 1'b1;
        tick();
        check("done_pulse", {7'd0, acknowledge_done}, 8'h01);
        check("done_enable_off", {7'd0, data_out_enable}, 8'h00);
        check("done_data_off", data_out, 8'h00);
        check("done_state", {6'd0, control_state}, 8'h00);
        check("done_selected_hold", {7'd0, selected}, {7'd0, v.exp_sel});
        tick();
        check("done_single_pulse", {7'd0, acknowledge_done}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //                  mode  id    cas   pend  lvl   vb         gap isr    sel   data   to
        table_v[0] = '{1'b1, 3'd5, 3'd5, 1'b1, 3'd2, 5'b01000, 2, 8'h04, 1'b1, 8'h42, 1'b0};
        table_v[1] = '{1'b1, 3'd5, 3'd3, 1'b1, 3'd2, 5'b01000, 2, 8'h00, 1'b0, 8'h00, 1'b0};
        table_v[2] = '{1'b1, 3'd5, 3'd5, 1'b0, 3'd2, 5'b01000, 2, 8'h00, 1'b1, 8'h47, 1'b0};
        table_v[3] = '{1'b1, 3'd5, 3'd5, 1'b1, 3'd2, 5'b01000, 4, 8'h04, 1'b1, 8'h00, 1'b1};
        table_v[4] = '{1'b0, 3'd5, 3'd5, 1'b1, 3'd2, 5'b01000, 1, 8'h00, 1'b0, 8'h00, 1'b0};
        table_v[5] = '{1'b1, 3'd0, 3'd0, 1'b1, 3'd7, 5'b11111, 3, 8'h80, 1'b1, 8'hFF, 1'b0};
        table_v[6] = '{1'b1, 3'd7, 3'd7, 1'b1, 3'd0, 5'b00001, 0, 8'h01, 1'b1, 8'h08, 1'b0};

        reset = 1'b1; icw1 = 1'b0; inta_n = 1'b1;
        slave_mode = 1'b0; slave_id = 3'd0; cascade_in = 3'd0;
        interrupt_pending = 1'b0; highest_level = 3'd0; vector_base = 5'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_state", {6'd0, control_state}, 8'h00);
        check("reset_selected", {7'd0, selected}, 8'h00);
        check("reset_isr", in_service_set, 8'h00);
        check("reset_data", data_out, 8'h00);
        check("reset_enable", {7'd0, data_out_enable}, 8'h00);
        check("reset_done", {7'd0, acknowledge_done}, 8'h00);

        for (int k = 0; k < 7; k++) run_txn(table_v[k], 1 + (k % 3), 2 + (k % 2), 1'b0);

        // ICW1 write while the vector is on the bus.
        slave_mode = 1'b1; slave_id = 3'd5; cascade_in = 3'd5;
        interrupt_pending = 1'b1; highest_level = 3'd2; vector_base = 5'b01000;
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick(); tick();
        inta_n = 1'b0; tick(); tick();
        check("pre_icw1_enable", {7'd0, data_out_enable}, 8'h01);
        check("pre_icw1_data", data_out, 8'h42);
        icw1 = 1'b1; tick();
        check("icw1_enable", {7'd0, data_out_enable}, 8'h00);
        check("icw1_state", {6'd0, control_state}, 8'h00);
        check("icw1_data", data_out, 8'h00);
        check("icw1_selected", {7'd0, selected}, 8'h00);
        icw1 = 1'b0; inta_n = 1'b1; tick();
        check("icw1_after_state", {6'd0, control_state}, 8'h00);
        check("icw1_after_done", {7'd0, acknowledge_done}, 8'h00);

        // Asynchronous reset in the middle of ACK1.
        inta_n = 1'b0; tick();
        check("pre_areset_state", {6'd0, control_state}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("areset_state", {6'd0, control_state}, 8'h00);
        check("areset_selected", {7'd0, selected}, 8'h00);
        check("areset_isr", in_service_set, 8'h00);
        check("areset_enable", {7'd0, data_out_enable}, 8'h00);
        inta_n = 1'b1; tick();
        reset = 1'b0; tick();
        check("areset_idle", {6'd0, control_state}, 8'h00);

        for (int k = 0; k < 40; k++) begin
            v.mode    = ($urandom_range(0, 3) != 0);
            v.id      = $urandom_range(0, 7);
            v.cas     = ($urandom_range(0, 1) != 0) ? v.id : 3'($urandom_range(0, 7));
            v.pending = ($urandom_range(0, 3) != 0);
            v.level   = $urandom_range(0, 7);
            v.vb      = $urandom_range(0, 31);
            v.gap     = $urandom_range(0, 5);
            v = model(v);
            run_txn(v, $urandom_range(1, 3), $urandom_range(2, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cascade_slave_responder.md
Name: cascade_slave_responder

Overview:
- Slave-side end of the 8259 cascade bus, used when the device is programmed as a cascaded slave.
- Tracks the two-pulse 8086 INTA sequence and captures the CAS2-CAS0 ID that the master drives.
- Compares that ID against its own ICW3 slave ID.
- When selected, it pulses the in-service set for the acknowledged level and drives the interrupt vector on the second INTA.
- Sits between the cascade I/O pins, the priority resolver and the data-bus buffer.

Parameters:
TIMEOUT_CYCLES, 255, clock cycles allowed in WAIT2 before the sequence aborts; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
write_initial_command_word_1_reset  input  1  synchronous clear from an ICW1 write; highest priority after reset
slave_mode  input  1  1 = cascade configured and SP/EN low
slave_id  input  3  ICW3 ID2-ID0
interrupt_acknowledge_n  input  1  CPU INTA, active low, synchronous to clock
cascade_in  input  3  CAS2-CAS0 as seen on the pins
interrupt_pending  input  1  priority resolver has an unmasked request
highest_level  input  3  level chosen by the priority resolver
vector_base  input  5  ICW2 T7-T3
selected  output  1  this slave was addressed in the current sequence
in_service_set  output  8  one-hot, single-cycle pulse to set an ISR bit
data_out  output  8  vector byte
data_out_enable  output  1  drive data_out onto the data bus
acknowledge_done  output  1  single-cycle pulse at the end of the second INTA
control_state  output  2  IDLE=00, ACK1=01, ACK2=10, WAIT2=11

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0, latched level 0.
- Edge detection:
  - inta_prev is registered each cycle and reset to 1.
  - fall = inta_prev & ~inta_n.
  - rise = ~inta_prev & inta_n.
- IDLE:
  - On fall -> ACK1.
  - On entry to ACK1, selected clears to 0.
- ACK1:
  - On rise, CAS is sampled: selected <= slave_mode & (cascade_in == slave_id).
  - The level is latched as highest_level if interrupt_pending is 1, otherwise 3'd7 (spurious IR7).
  - If selected and interrupt_pending, in_service_set pulses (1 << level) for exactly that one cycle.
  - State -> WAIT2, and the timeout counter clears.
- WAIT2:
  - The counter increments each cycle.
  - On fall -> ACK2.
  - If the counter reaches TIMEOUT_CYCLES with no fall -> IDLE, selected <= 0, no acknowledge_done.
  - fall and timeout in the same cycle: fall wins.
- ACK2:
  - data_out_enable = selected & ~interrupt_acknowledge_n, registered, so it asserts one cycle after fall.
  - data_out = {vector_base, level} whenever data_out_enable is 1, else 8'h00.
  - On rise: data_out_enable <= 0, acknowledge_done pulses 1 cycle, state -> IDLE.
  - selected holds its value until the next ACK1 entry.
- Non-slave operation:
  - slave_mode=0: the FSM still sequences, but selected stays 0.
  - Consequently in_service_set, data_out and data_out_enable stay 0.
- Configuration changes: slave_mode or slave_id changing mid-sequence affects only the next ACK1 sampling; values already latched are kept.
- Abort paths:
  - write_initial_command_word_1_reset=1: synchronous return to IDLE with all outputs 0, taking precedence over any edge in the same cycle.
  - Asynchronous reset mid-sequence has the same effect immediately.
- inta_n held low indefinitely in ACK1 or ACK2: the FSM waits; there is no timeout in those states.

Decomposition:
- Shared package (common): state encodings IDLE/ACK1/ACK2/WAIT2 and the spurious level constant 3'd7.
- One natural sub-module, inta_edge_detect: registered inta_prev with fall/rise outputs.
- The one-hot decode reuses the common helper style.

Test Plan:
- Addressed slave, pending request:
  - Stimulus: slave_id=3'd5, slave_mode=1, pending=1, level=3'd2, vector_base=5'b01000; first INTA with CAS=5, then second INTA.
  - Required: in_service_set=8'h04 pulse at the first rise; data_out=8'h42 with data_out_enable during the second INTA low; acknowledge_done pulse at its rise.
- Mismatched ID:
  - Stimulus: CAS=3 with slave_id=5.
  - Required: selected=0; no in_service_set pulse; data_out_enable stays 0; acknowledge_done still pulses.
- Spurious acknowledge:
  - Stimulus: pending=0, CAS match, vector_base=5'b01000.
  - Required: no ISR pulse; data_out=8'h47 on the second INTA.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; first INTA only.
  - Required: state returns to IDLE 4 cycles after entering WAIT2; a later single INTA re-enters ACK1 normally.
- Mid-sequence clears:
  - Stimulus: write_initial_command_word_1_reset during ACK2 with data_out_enable=1.
  - Required: next cycle data_out_enable=0 and state=IDLE.
  - Stimulus: asynchronous reset asserted mid-ACK1.
  - Required: all outputs 0 immediately.
- slave_mode=0:
  - Stimulus: full two-INTA sequence with matching CAS.
  - Required: control_state walks 01, 11, 10, 00 while selected, in_service_set and data_out_enable stay 0.
